// File: rtl/rx_adc_sampler_if.sv
// Serial ADC pins plus the captured-sample output stream of the receive front end.
// The sampler drives through master; the ADC and the downstream decimator sit on slave.
interface rx_adc_sampler_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    oadc_convst;
    logic                    oadc_cs_n;
    logic                    oadc_sclk;
    logic                    iadc_sdo;
    logic [SAMPLE_WIDTH-1:0] osample;
    logic                    onew_sample_trigg;

    modport master (
        output oadc_convst, oadc_cs_n, oadc_sclk, osample, onew_sample_trigg,
        input  iadc_sdo
    );

    modport slave (
        input  oadc_convst, oadc_cs_n, oadc_sclk, osample, onew_sample_trigg,
        output iadc_sdo
    );
endinterface

// File: rtl/rx_adc_sampler.sv
// Paces serial ADC conversions from a sample-rate counter and shifts each word in MSB-first.
// Presents every captured word with a one-cycle strobe for the rx decimator.
module rx_adc_sampler #(
    parameter int CLK_DIV_SAMPLE = 100,
    parameter int CONV_CYCLES    = 10,
    parameter int SCLK_HALF      = 2,
    parameter int SAMPLE_WIDTH   = 16
) (
    input  logic                     crx_clk,
    input  logic                     rrx_rst,
    input  logic                     erx_en,
    rx_adc_sampler_if.master         adc,
    output logic                     obusy,
    output logic                     ooverrun
);
    localparam int PW   = (CLK_DIV_SAMPLE > 1) ? $clog2(CLK_DIV_SAMPLE) : 1;
    localparam int HMAX = (CONV_CYCLES > SCLK_HALF) ? CONV_CYCLES : SCLK_HALF;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int BW   = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_e;

    state_e                  state_q;
    logic [PW-1:0]           per_q, per_d;
    logic [HW-1:0]           half_q;
    logic [BW-1:0]           bit_q;
    logic [SAMPLE_WIDTH-1:0] shreg_q, sample_q;
    logic                    convst_q, cs_n_q, sclk_q, trig_q, ovr_q;
    logic                    tick;

    always_comb begin
        per_d = per_q;
        if (!erx_en)
            per_d = '0;
        else if (per_q == PW'(CLK_DIV_SAMPLE - 1))
            per_d = '0;
        else
            per_d = per_q + 1'b1;
    end

    assign tick = erx_en && (per_q == '0);

    // half_q times the convert window and then each SCLK half period.
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state_q  <= IDLE;
            per_q    <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sample_q <= '0;
            convst_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            trig_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else if (!erx_en) begin
            state_q  <= IDLE;
            per_q    <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            convst_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            trig_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            per_q  <= per_d;
            trig_q <= 1'b0;
            ovr_q  <= tick && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q  <= CONVERT;
                        convst_q <= 1'b1;
                        half_q   <= '0;
                    end
                end
                CONVERT: begin
                    if (half_q == HW'(CONV_CYCLES - 1)) begin
                        state_q  <= SHIFT;
                        convst_q <= 1'b0;
                        cs_n_q   <= 1'b0;
                        sclk_q   <= 1'b0;
                        half_q   <= '0;
                        bit_q    <= '0;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_q == HW'(SCLK_HALF - 1)) begin
                        half_q <= '0;
                        if (!sclk_q) begin
                            // Data is taken on the same edge that raises SCLK.
                            sclk_q  <= 1'b1;
                            shreg_q <= (shreg_q << 1) | SAMPLE_WIDTH'(adc.iadc_sdo);
                        end else if (bit_q == BW'(SAMPLE_WIDTH - 1)) begin
                            // Word is complete; publish it as DONE is entered.
                            state_q  <= DONE;
                            cs_n_q   <= 1'b1;
                            sclk_q   <= 1'b0;
                            sample_q <= shreg_q;
                            trig_q   <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                        end
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc.oadc_convst       = convst_q;
    assign adc.oadc_cs_n         = cs_n_q;
    assign adc.oadc_sclk         = sclk_q;
    assign adc.osample           = sample_q;
    assign adc.onew_sample_trigg = trig_q;
    assign obusy                 = (state_q != IDLE);
    assign ooverrun              = ovr_q;
endmodule

// File: tb/tb_rx_adc_sampler.sv
// Directed bench for rx_adc_sampler: a default-rate instance and an over-fast (DIV=40) one,
// each fed by a behavioural serial ADC that returns a programmable 16-bit word.
module tb_rx_adc_sampler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, en0 = 1'b0, rst1 = 1'b1, en1 = 1'b0;
    logic busy0, ovr0, busy1, ovr1;
    int   vecs = 0, errs = 0;

    rx_adc_sampler_if #(.SAMPLE_WIDTH(16)) bus0 ();
    rx_adc_sampler_if #(.SAMPLE_WIDTH(16)) bus1 ();

    rx_adc_sampler #(.CLK_DIV_SAMPLE(100), .CONV_CYCLES(10), .SCLK_HALF(2), .SAMPLE_WIDTH(16)) dut0 (
        .crx_clk(clk), .rrx_rst(rst0), .erx_en(en0), .adc(bus0), .obusy(busy0), .ooverrun(ovr0));
    rx_adc_sampler #(.CLK_DIV_SAMPLE(40), .CONV_CYCLES(10), .SCLK_HALF(2), .SAMPLE_WIDTH(16)) dut1 (
        .crx_clk(clk), .rrx_rst(rst1), .erx_en(en1), .adc(bus1), .obusy(busy1), .ooverrun(ovr1));

    // ADC models: bit index advances after each observed SCLK rise, restarts while CS is high.
    logic [15:0] word0 = '0, word1 = '0;
    logic [4:0]  idx0 = '0, idx1 = '0;
    logic        sprev0 = 1'b0, sprev1 = 1'b0;
    int          rises0 = 0, strobes0 = 0, ovrs0 = 0;

    assign bus0.iadc_sdo = (!bus0.oadc_cs_n && idx0 < 5'd16) ? word0[4'(15 - idx0)] : 1'b0;
    assign bus1.iadc_sdo = (!bus1.oadc_cs_n && idx1 < 5'd16) ? word1[4'(15 - idx1)] : 1'b0;

    always @(posedge clk) begin
        sprev0 <= bus0.oadc_sclk;
        if (bus0.oadc_cs_n === 1'b1) idx0 <= '0;
        else if (bus0.oadc_sclk === 1'b1 && sprev0 === 1'b0) idx0 <= idx0 + 5'd1;
        if (bus0.oadc_sclk === 1'b1 && sprev0 === 1'b0) rises0 <= rises0 + 1;
        if (bus0.onew_sample_trigg === 1'b1) strobes0 <= strobes0 + 1;
        if (ovr0 === 1'b1) ovrs0 <= ovrs0 + 1;
    end

    always @(posedge clk) begin
        sprev1 <= bus1.oadc_sclk;
        if (bus1.oadc_cs_n === 1'b1) idx1 <= '0;
        else if (bus1.oadc_sclk === 1'b1 && sprev1 === 1'b0) idx1 <= idx1 + 5'd1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        step(3);
        vecs++;
        if ({bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk, bus0.onew_sample_trigg, busy0, ovr0} !== 6'b010000) begin
            errs++;
            $display("FAIL reset_ctrl0 got %b want 010000", {bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk, bus0.onew_sample_trigg, busy0, ovr0});
        end
        vecs++;
        if (bus0.osample !== 16'h0000) begin
            errs++; $display("FAIL reset_sample0 got %h want 0000", bus0.osample);
        end
        vecs++;
        if ({bus1.oadc_convst, bus1.oadc_cs_n, bus1.oadc_sclk, bus1.onew_sample_trigg, busy1, ovr1, bus1.osample} !== {6'b010000, 16'h0}) begin
            errs++; $display("FAIL reset_dut1 got %b/%h want 010000/0000", {bus1.oadc_convst, bus1.oadc_cs_n, bus1.oadc_sclk, bus1.onew_sample_trigg, busy1, ovr1}, bus1.osample);
        end
        rst0 = 1'b0; rst1 = 1'b0;
        step(3);
        vecs++;
        if (busy0 !== 1'b0 || bus0.oadc_convst !== 1'b0) begin
            errs++; $display("FAIL idle_when_disabled busy=%b convst=%b want 0/0", busy0, bus0.oadc_convst);
        end
    endtask

    task automatic test_first_capture;
        int hi, r;
        word0 = 16'hA5C3;
        r = rises0;
        en0 = 1'b1;
        vecs++;
        if (bus0.oadc_convst !== 1'b0) begin
            errs++; $display("FAIL convst_at_E got %b want 0", bus0.oadc_convst);
        end
        step(1);
        vecs++;
        if (bus0.oadc_convst !== 1'b1 || busy0 !== 1'b1) begin
            errs++; $display("FAIL convst_at_E1 convst=%b busy=%b want 1/1", bus0.oadc_convst, busy0);
        end
        hi = 1;
        for (int k = 2; k <= 10; k++) begin
            step(1);
            if (bus0.oadc_convst === 1'b1) hi++;
        end
        vecs++;
        if (hi !== 10) begin
            errs++; $display("FAIL convst_width got %0d want 10", hi);
        end
        step(1);
        vecs++;
        if ({bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk} !== 3'b000) begin
            errs++; $display("FAIL shift_entry got %b want 000", {bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk});
        end
        step(63);
        vecs++;
        if (bus0.oadc_cs_n !== 1'b0 || bus0.onew_sample_trigg !== 1'b0) begin
            errs++; $display("FAIL at_E74 cs_n=%b trig=%b want 0/0", bus0.oadc_cs_n, bus0.onew_sample_trigg);
        end
        step(1);
        vecs++;
        if (bus0.onew_sample_trigg !== 1'b1 || bus0.osample !== 16'hA5C3 || bus0.oadc_cs_n !== 1'b1) begin
            errs++; $display("FAIL strobe_E75 trig=%b sample=%h cs_n=%b want 1/a5c3/1", bus0.onew_sample_trigg, bus0.osample, bus0.oadc_cs_n);
        end
        vecs++;
        if (rises0 - r !== 16) begin
            errs++; $display("FAIL sclk_rises got %0d want 16", rises0 - r);
        end
        step(1);
        vecs++;
        if (bus0.onew_sample_trigg !== 1'b0 || bus0.osample !== 16'hA5C3) begin
            errs++; $display("FAIL strobe_width trig=%b sample=%h want 0/a5c3", bus0.onew_sample_trigg, bus0.osample);
        end
    endtask

    task automatic test_continuous;
        logic [15:0] lw [4];
        logic [15:0] held;
        int rel, prev, w, chg, ov;
        lw[0] = 16'h8000; lw[1] = 16'h7FFF; lw[2] = 16'h1234; lw[3] = 16'h00FF;
        rel = 76; prev = 75; held = 16'hA5C3; ov = ovrs0;
        word0 = lw[0];
        for (int i = 0; i < 4; i++) begin
            w = 0; chg = 0;
            while (w < 150) begin
                step(1); rel++; w++;
                if (bus0.onew_sample_trigg === 1'b1) break;
                if (bus0.osample !== held) chg++;
            end
            vecs++;
            if (bus0.onew_sample_trigg !== 1'b1 || rel - prev !== 100) begin
                errs++; $display("FAIL strobe_spacing[%0d] got %0d want 100", i, rel - prev);
            end
            vecs++;
            if (bus0.osample !== lw[i]) begin
                errs++; $display("FAIL sample_value[%0d] got %h want %h", i, bus0.osample, lw[i]);
            end
            vecs++;
            if (chg !== 0) begin
                errs++; $display("FAIL sample_hold[%0d] changed %0d cycles want 0", i, chg);
            end
            prev = rel; held = lw[i];
            if (i < 3) word0 = lw[i + 1];
        end
        vecs++;
        if (ovrs0 - ov !== 0) begin
            errs++; $display("FAIL no_overrun got %0d pulses want 0", ovrs0 - ov);
        end
    endtask

    task automatic test_disable_mid_shift;
        logic [15:0] held;
        int w, s;
        w = 0;
        while (bus0.oadc_cs_n !== 1'b0 && w < 150) begin step(1); w++; end
        vecs++;
        if (bus0.oadc_cs_n !== 1'b0) begin
            errs++; $display("FAIL wait_cs_low timed out cs_n=%b want 0", bus0.oadc_cs_n);
        end
        step(21);
        held = bus0.osample; s = strobes0;
        en0 = 1'b0;
        step(1);
        vecs++;
        if ({bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk, busy0} !== 4'b0100) begin
            errs++; $display("FAIL abort_state got %b want 0100", {bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk, busy0});
        end
        step(100);
        vecs++;
        if (strobes0 !== s || bus0.osample !== held || busy0 !== 1'b0) begin
            errs++; $display("FAIL abort_quiet strobes=%0d sample=%h busy=%b want %0d/%h/0", strobes0 - s, bus0.osample, busy0, 0, held);
        end
        word0 = 16'h5A5A;
        en0 = 1'b1;
        step(75);
        vecs++;
        if (bus0.onew_sample_trigg !== 1'b1 || bus0.osample !== 16'h5A5A) begin
            errs++; $display("FAIL reenable_capture trig=%b sample=%h want 1/5a5a", bus0.onew_sample_trigg, bus0.osample);
        end
    endtask

    task automatic test_reset_mid_convert;
        int w;
        w = 0;
        while (bus0.oadc_convst !== 1'b1 && w < 150) begin step(1); w++; end
        vecs++;
        if (bus0.oadc_convst !== 1'b1) begin
            errs++; $display("FAIL wait_convst timed out convst=%b want 1", bus0.oadc_convst);
        end
        step(3);
        rst0 = 1'b1;
        step(1);
        vecs++;
        if ({bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk, bus0.onew_sample_trigg, busy0, ovr0} !== 6'b010000 || bus0.osample !== 16'h0) begin
            errs++; $display("FAIL reset_mid_convert got %b/%h want 010000/0000", {bus0.oadc_convst, bus0.oadc_cs_n, bus0.oadc_sclk, bus0.onew_sample_trigg, busy0, ovr0}, bus0.osample);
        end
        rst0 = 1'b0;
        word0 = 16'h0F0F;
        step(75);
        vecs++;
        if (bus0.onew_sample_trigg !== 1'b1 || bus0.osample !== 16'h0F0F) begin
            errs++; $display("FAIL post_reset_capture trig=%b sample=%h want 1/0f0f", bus0.onew_sample_trigg, bus0.osample);
        end
        en0 = 1'b0;
    endtask

    task automatic test_overrun;
        word1 = 16'h3C96;
        en1 = 1'b1;
        step(40);
        vecs++;
        if (ovr1 !== 1'b0 || busy1 !== 1'b1) begin
            errs++; $display("FAIL ovr_E40 ovr=%b busy=%b want 0/1", ovr1, busy1);
        end
        step(1);
        vecs++;
        if (ovr1 !== 1'b1) begin
            errs++; $display("FAIL ovr_E41 got %b want 1", ovr1);
        end
        step(1);
        vecs++;
        if (ovr1 !== 1'b0) begin
            errs++; $display("FAIL ovr_E42 got %b want 0", ovr1);
        end
        step(33);
        vecs++;
        if (bus1.onew_sample_trigg !== 1'b1 || bus1.osample !== 16'h3C96) begin
            errs++; $display("FAIL ovr_word1 trig=%b sample=%h want 1/3c96", bus1.onew_sample_trigg, bus1.osample);
        end
        word1 = 16'hC369;
        step(6);
        vecs++;
        if (bus1.oadc_convst !== 1'b1) begin
            errs++; $display("FAIL ovr_next_convst got %b want 1", bus1.oadc_convst);
        end
        step(40);
        vecs++;
        if (ovr1 !== 1'b1) begin
            errs++; $display("FAIL ovr_E121 got %b want 1", ovr1);
        end
        step(34);
        vecs++;
        if (bus1.onew_sample_trigg !== 1'b1 || bus1.osample !== 16'hC369) begin
            errs++; $display("FAIL ovr_word2 trig=%b sample=%h want 1/c369", bus1.onew_sample_trigg, bus1.osample);
        end
        en1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_continuous();
        test_disable_mid_shift();
        test_reset_mid_convert();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/rx_adc_sampler.md
Name: rx_adc_sampler

Overview:
- Front-end stage of the receive chain. Paces ADC conversions from a programmable sample-rate counter.
- Drives a serial ADC: convst pulse, then a chip-select frame, shifting SAMPLE_WIDTH bits MSB-first.
- Presents each captured word on osample with a one-cycle onew_sample_trigg strobe. The rx decimator consumes that strobe as its input sample trigger.

Parameters:
- CLK_DIV_SAMPLE, 100: crx_clk cycles per sample period.
- CONV_CYCLES, 10: cycles oadc_convst is held high (ADC conversion time).
- SCLK_HALF, 2: crx_clk cycles per SCLK half period (must be ≥1).
- SAMPLE_WIDTH, 16: bits per ADC word.
- Legality: CLK_DIV_SAMPLE ≥ CONV_CYCLES + 2*SCLK_HALF*SAMPLE_WIDTH + 3. A violation is a configuration error but still gives defined overrun behaviour.

Ports:
- crx_clk  in  1  clock, all logic on rising edge.
- rrx_rst  in  1  reset, synchronous, active-high.
- erx_en  in  1  enable; low aborts activity and holds the block idle.
- iadc_sdo  in  1  ADC serial data out.
- oadc_convst  out  1  conversion start, active-high.
- oadc_cs_n  out  1  ADC chip select, active-low.
- oadc_sclk  out  1  ADC serial clock, idles low.
- osample  out  SAMPLE_WIDTH  last captured word, two's complement, held between captures.
- onew_sample_trigg  out  1  one-cycle strobe: osample updated this cycle.
- obusy  out  1  high while state ≠ IDLE.
- ooverrun  out  1  one-cycle pulse: sample tick arrived while not IDLE.

Behaviour:
- Reset (rrx_rst=1, wins over everything):
  - state IDLE, period counter 0, bit counter 0, half counter 0.
  - oadc_convst=0, oadc_cs_n=1, oadc_sclk=0, osample=0, onew_sample_trigg=0, obusy=0, ooverrun=0.
- Period counter:
  - Counts 0..CLK_DIV_SAMPLE-1 and wraps while erx_en=1.
  - tick = erx_en & (counter==0). The first tick therefore occurs in the first enabled cycle; later ticks are exactly CLK_DIV_SAMPLE cycles apart.
- FSM states: IDLE, CONVERT, SHIFT, DONE.
  - IDLE: on tick, go to CONVERT and set oadc_convst=1.
  - CONVERT: oadc_convst high for exactly CONV_CYCLES cycles. Then go to SHIFT with oadc_convst=0, oadc_cs_n=0, oadc_sclk=0.
  - SHIFT: each bit is SCLK_HALF cycles with sclk low, then SCLK_HALF cycles with sclk high.
    - iadc_sdo is captured into the shift register (MSB first, shift left) on the clock edge that drives oadc_sclk 0→1.
    - After the high phase of bit SAMPLE_WIDTH-1, go to DONE with oadc_cs_n=1, oadc_sclk=0.
  - DONE (one cycle): osample is loaded with the shift register, onew_sample_trigg=1, then return to IDLE.
- Latency: for a tick in cycle T:
  - oadc_convst is high T+1..T+CONV_CYCLES.
  - oadc_cs_n is low T+CONV_CYCLES+1 .. T+CONV_CYCLES+2*SCLK_HALF*SAMPLE_WIDTH.
  - The strobe and new osample appear at T+CONV_CYCLES+2*SCLK_HALF*SAMPLE_WIDTH+1. With defaults this is T+75.
- Overrun: a tick while state ≠ IDLE is dropped. ooverrun pulses for one cycle and the current conversion continues unaffected.
- erx_en=0, any state:
  - Next cycle: state IDLE, counters 0, oadc_convst=0, oadc_cs_n=1, oadc_sclk=0.
  - No strobe is issued and osample holds its prior value. A partial word is discarded.
- Re-enable: a fresh tick occurs on the first cycle with erx_en=1.
- Simultaneous DONE and tick: cannot occur under the legality rule. If it does occur, DONE completes and ooverrun pulses.
- onew_sample_trigg is never high for two consecutive cycles.

Test Plan:
- Defaults, ADC model returns 0xA5C3:
  - first tick at enable cycle E;
  - convst high E+1..E+10;
  - 16 sclk rising edges;
  - osample=0xA5C3 with strobe at E+75, one cycle wide.
- Continuous run of 5 samples → strobes exactly 100 cycles apart; osample holds between strobes; ooverrun never asserts.
- Model returns 0x8000 then 0x7FFF → osample=0x8000 then 0x7FFF, bit-exact MSB-first ordering.
- erx_en dropped during the 6th SHIFT bit → next cycle cs_n=1, sclk=0, obusy=0, no strobe, osample unchanged. Re-enable → new capture completes 75 cycles later.
- rrx_rst asserted mid-CONVERT → all outputs at reset values next cycle, osample=0. After release with erx_en=1, normal capture resumes.
- CLK_DIV_SAMPLE=40 (illegal) → the tick during SHIFT gives a one-cycle ooverrun pulse; the in-flight word is still delivered correctly; the next capture starts on the following tick in IDLE.
